// File: rtl/mips20_pkg.sv
// Shared definitions for the 20-bit MIPS core: instruction field layout,
// opcode encodings and the control-bit bundle produced by the decoder.
package mips20_pkg;

  localparam int IW   = 20;
  localparam int RW   = 3;
  localparam int OPW  = 4;
  localparam int FW   = 4;
  localparam int IMMW = 10;

  localparam int OPC_LSB   = 16;
  localparam int RS_LSB    = 13;
  localparam int RT_LSB    = 10;
  localparam int RD_LSB    = 7;
  localparam int FUNCT_LSB = 3;
  localparam int IMM_LSB   = 0;

  localparam logic [OPW-1:0] OP_RTYPE = 4'd0;
  localparam logic [OPW-1:0] OP_ADDI  = 4'd1;
  localparam logic [OPW-1:0] OP_ANDI  = 4'd2;
  localparam logic [OPW-1:0] OP_ORI   = 4'd3;
  localparam logic [OPW-1:0] OP_LW    = 4'd4;
  localparam logic [OPW-1:0] OP_SW    = 4'd5;
  localparam logic [OPW-1:0] OP_BEQ   = 4'd6;
  localparam logic [OPW-1:0] OP_NOP   = 4'd7;

  // Field order matches the (regwrite,memread,memwrite,branch,alusrc,extd) table.
  typedef struct packed {
    logic regwrite;
    logic memread;
    logic memwrite;
    logic branch;
    logic alusrc;
    logic extd;
  } ctrl_t;

  function automatic logic [RW-1:0] reg_field(input logic [IW-1:0] instr, input int lsb);
    return instr[lsb +: RW];
  endfunction

endpackage

// File: rtl/mips20_ctrl_decode.sv
// Combinational opcode decoder: control bits, immediate extension select,
// illegal-opcode flag and which source registers the instruction reads.
module mips20_ctrl_decode
  import mips20_pkg::*;
(
  input  logic [OPW-1:0] opcode_i,
  output ctrl_t          ctrl_o,
  output logic           illegal_o,
  output logic           reads_rs_o,
  output logic           reads_rt_o
);

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    ctrl_o     = '0;
    illegal_o  = 1'b0;
    reads_rs_o = 1'b0;
    reads_rt_o = 1'b0;
    unique case (opcode_i)
      OP_RTYPE: begin
        ctrl_o     = '{regwrite: 1'b1, default: 1'b0};
        reads_rs_o = 1'b1;
        reads_rt_o = 1'b1;
      end
      OP_ADDI: begin
        ctrl_o     = '{regwrite: 1'b1, alusrc: 1'b1, extd: 1'b1, default: 1'b0};
        reads_rs_o = 1'b1;
      end
      OP_ANDI, OP_ORI: begin
        ctrl_o     = '{regwrite: 1'b1, alusrc: 1'b1, default: 1'b0};
        reads_rs_o = 1'b1;
      end
      OP_LW: begin
        ctrl_o     = '{regwrite: 1'b1, memread: 1'b1, alusrc: 1'b1, extd: 1'b1, default: 1'b0};
        reads_rs_o = 1'b1;
      end
      OP_SW: begin
        ctrl_o     = '{memwrite: 1'b1, alusrc: 1'b1, extd: 1'b1, default: 1'b0};
        reads_rs_o = 1'b1;
        reads_rt_o = 1'b1;
      end
      OP_BEQ: begin
        ctrl_o     = '{branch: 1'b1, extd: 1'b1, default: 1'b0};
        reads_rs_o = 1'b1;
        reads_rt_o = 1'b1;
      end
      OP_NOP: ctrl_o = '0;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/if_id_decode_stage.sv
// IF/ID stage: one-entry instruction register with valid/ready handshake,
// combinational decode of the held instruction, load-use bubble and flush.
module if_id_decode_stage
  import mips20_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IW-1:0]   in_instr,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [OPW-1:0]  out_opcode,
  output logic [RW-1:0]   out_rs,
  output logic [RW-1:0]   out_rt,
  output logic [RW-1:0]   out_rd,
  output logic [FW-1:0]   out_funct,
  output logic [IMMW-1:0] out_imm,
  output logic            out_extd,
  output logic            out_regwrite,
  output logic            out_memread,
  output logic            out_memwrite,
  output logic            out_branch,
  output logic            out_alusrc,
  output logic            out_illegal
);

  logic          held_valid_q, held_valid_d;
  logic [IW-1:0] instr_q, instr_d;
  logic          ld_pending_q, ld_pending_d;
  logic [RW-1:0] ld_rt_q, ld_rt_d;

  logic [OPW-1:0] opcode;
  logic [RW-1:0]  rs, rt;
  ctrl_t          ctrl;
  logic           illegal, reads_rs, reads_rt;
  logic           is_rtype, load_use, drop_illegal, out_fire, in_fire;

  assign opcode   = instr_q[OPC_LSB +: OPW];
  assign rs       = reg_field(instr_q, RS_LSB);
  assign rt       = reg_field(instr_q, RT_LSB);
  assign is_rtype = (opcode == OP_RTYPE);

  mips20_ctrl_decode u_ctrl_decode (
    .opcode_i   (opcode),
    .ctrl_o     (ctrl),
    .illegal_o  (illegal),
    .reads_rs_o (reads_rs),
    .reads_rt_o (reads_rt)
  );

  // The instruction right behind an LW may not consume the loaded register yet.
  assign load_use = held_valid_q && ld_pending_q &&
                    ((reads_rs && rs == ld_rt_q) || (reads_rt && rt == ld_rt_q));
  assign drop_illegal = held_valid_q && illegal;

  assign out_valid = held_valid_q && !illegal && !load_use && !flush;
  assign out_fire  = out_valid && out_ready;
  assign in_ready  = !flush && !load_use && (!held_valid_q || out_fire);
  assign in_fire   = in_valid && in_ready;

  always_comb begin
    held_valid_d = held_valid_q;
    instr_d      = instr_q;
    ld_rt_d      = ld_rt_q;
    ld_pending_d = 1'b0;
    if (flush)                         held_valid_d = 1'b0;
    else if (in_fire)                  held_valid_d = 1'b1;
    else if (out_fire || drop_illegal) held_valid_d = 1'b0;
    if (in_fire) instr_d = in_instr;
    if (out_fire && opcode == OP_LW) begin
      ld_pending_d = 1'b1;
      ld_rt_d      = rt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held_valid_q <= 1'b0;
      instr_q      <= '0;
      ld_pending_q <= 1'b0;
      ld_rt_q      <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      held_valid_q <= held_valid_d;
      instr_q      <= instr_d;
      ld_pending_q <= ld_pending_d;
      ld_rt_q      <= ld_rt_d;
    end
  end

  // An empty stage presents all-zero fields rather than a stale instruction.
  assign out_opcode   = held_valid_q ? opcode : '0;
  assign out_rs       = held_valid_q ? rs : '0;
  assign out_rt       = held_valid_q ? rt : '0;
  assign out_rd       = !held_valid_q ? '0 : (is_rtype ? instr_q[RD_LSB +: RW] : rt);
  assign out_funct    = (held_valid_q && is_rtype) ? instr_q[FUNCT_LSB +: FW] : '0;
  assign out_imm      = held_valid_q ? instr_q[IMM_LSB +: IMMW] : '0;
  assign out_extd     = held_valid_q && ctrl.extd;
  assign out_regwrite = held_valid_q && ctrl.regwrite;
  assign out_memread  = held_valid_q && ctrl.memread;
  assign out_memwrite = held_valid_q && ctrl.memwrite;
  assign out_branch   = held_valid_q && ctrl.branch;
  assign out_alusrc   = held_valid_q && ctrl.alusrc;
  assign out_illegal  = drop_illegal;

endmodule
